// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative restoring divider, one quotient bit per clock.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start_i     request a new divide (accepted in IDLE or DONE only)
//   signed_i    1 = signed divide, 0 = unsigned; sampled with start_i
//   annul_i     abort the in-flight divide; also drops a same-cycle start
//   dividend_i  dividend, sampled only on the accept edge
//   divisor_i   divisor, sampled only on the accept edge
//   busy_o      divide in progress (registered)
//   ready_o     one-cycle pulse, result_o valid (registered)
//   result_o    {remainder, quotient}, held until the next completion
//   dbg_state   current FSM state (IDLE=0, BUSY=1, DONE=2) for checkers
//
// Handshake: a request is taken on a rising edge where start_i=1, annul_i=0
// and the unit is in IDLE or DONE. Completion is signalled by exactly one
// cycle of ready_o; busy_o and ready_o are never high together. A DONE
// cycle may accept a new start (back-to-back operation).
module div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem_q;   // partial remainder
  logic [WIDTH-1:0] quo_q;   // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dvs_q;   // magnitude of the divisor
  logic             q_neg;
  logic             r_neg;

  // Operand magnitudes for the accept edge.
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  // One restoring step.
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last;

  always_comb begin
    dvd_neg = signed_i & dividend_i[WIDTH-1];
    dvs_neg = signed_i & divisor_i[WIDTH-1];
    dvd_abs = dvd_neg ? -dividend_i : dividend_i;
    dvs_abs = dvs_neg ? -divisor_i  : divisor_i;

    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    ge      = (partial >= {1'b0, dvs_q});
    rem_nxt = ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ge};

    // Most-negative / -1 needs no special case: the magnitude quotient is
    // 2^(WIDTH-1) with a positive sign, which reads back as most-negative.
    q_fix   = q_neg ? -quo_nxt : quo_nxt;
    r_fix   = r_neg ? -rem_nxt : rem_nxt;
    last    = (cnt == 6'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      busy_o   <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        BUSY: begin
          if (annul_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + 6'd1;
            if (last) begin
              result_o <= {r_fix, q_fix};
              state    <= DONE;
              busy_o   <= 1'b0;
              ready_o  <= 1'b1;
            end
          end
        end
        default: begin  // IDLE and DONE behave alike apart from ready_o's pulse
          state   <= IDLE;
          busy_o  <= 1'b0;
          ready_o <= 1'b0;
          if (start_i && !annul_i) begin
            if (divisor_i == '0) begin
              // Divide by zero bypasses the iterations entirely.
              result_o <= {dividend_i, {WIDTH{1'b1}}};
              state    <= DONE;
              ready_o  <= 1'b1;
            end else begin
              rem_q  <= '0;
              quo_q  <= dvd_abs;
              dvs_q  <= dvs_abs;
              q_neg  <= dvd_neg ^ dvs_neg;
              r_neg  <= dvd_neg;
              cnt    <= '0;
              state  <= BUSY;
              busy_o <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit (WIDTH=32): a vector table plus
// hand-written sequences for annul, reset, back-to-back and ignored starts.
module tb_div_iter_unit;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic           annul_i;
  logic [W-1:0]   dividend_i;
  logic [W-1:0]   divisor_i;
  logic           busy_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;
  logic [1:0]     dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int overlap_seen = 0;

  div_iter_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .annul_i    (annul_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy/ready exclusivity is watched continuously on every sample point.
  always @(negedge clk) if (busy_o && ready_o) overlap_seen++;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // ---------------- drivers ----------------
  // Present a request for one edge, then scramble the operands so that any
  // late sampling of them corrupts the result.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0; signed_i = 1'($urandom_range(0, 1));
    dividend_i = $urandom; divisor_i = $urandom;
  endtask

  // Count busy samples until ready is seen, bounded.
  task automatic wait_done(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) begin got = 1'b1; return; end
      if (busy_o) busy_cycles++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_res;
    int             exp_busy;
  } vec_t;

  vec_t vecs[12];

  logic [2*W-1:0] exp_q[$];

  initial begin
    int  bc;
    bit  got;
    int  rdy_cnt;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] e;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}, 32};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}, 32};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          {32'h0000_0005, 32'hFFFF_FFFF}, 0};
    vecs[4]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0000_0000, 32'hFFFF_FFFF}, 32};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h0000_0001}, 32};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 32};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'h0000_0003}, 32};
    vecs[9]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          {32'h0000_0001, 32'h7FFF_FFFC}, 32};
    vecs[10] = '{1'b0, 32'd3,          32'd10,         {32'h0000_0003, 32'h0000_0000}, 32};
    vecs[11] = '{1'b1, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}, 32};

    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_busy",   {63'd0, busy_o},  '0);
    check("reset_ready",  {63'd0, ready_o}, '0);
    check("reset_result", result_o,         '0);

    // Table
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_res);
    foreach (vecs[i]) begin
      issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_done(bc, got);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_ready", i), {63'd0, got}, 64'd1);
      check($sformatf("vec%0d_result", i), result_o, e);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].exp_busy));
      @(negedge clk);
      check($sformatf("vec%0d_ready_pulse", i), {63'd0, ready_o}, '0);
    end
    prev = vecs[11].exp_res;

    // Annul at the 10th busy cycle
    issue(1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) @(negedge clk);
    @(negedge clk);
    check("annul_busy_before", {63'd0, busy_o}, 64'd1);
    annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0;
    @(negedge clk);
    check("annul_busy_after", {63'd0, busy_o}, '0);
    check("annul_result_kept", result_o, prev);
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) rdy_cnt++;
    end
    check("annul_no_ready", 64'(rdy_cnt), '0);

    // annul and start together in IDLE: start dropped
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5;
    @(posedge clk);
    #1 start_i = 1'b0; annul_i = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o || busy_o) rdy_cnt++;
    end
    check("annul_start_dropped", 64'(rdy_cnt), '0);
    check("annul_start_result", result_o, prev);

    // Reset mid-BUSY, then a normal divide
    issue(1'b0, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {result_o[61:0], busy_o, ready_o}, '0);
    check("rst_result_hi", {32'd0, result_o[63:32]}, '0);
    issue(1'b0, 32'd9, 32'd3);
    wait_done(bc, got);
    check("post_rst_ready", {63'd0, got}, 64'd1);
    check("post_rst_result", result_o, {32'h0, 32'h3});
    check("post_rst_busy_cycles", 64'(bc), 64'd32);

    // Back-to-back: new start in the DONE cycle
    issue(1'b0, 32'd100, 32'd7);
    wait_done(bc, got);
    check("b2b_first_result", result_o, {32'h2, 32'hE});
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd15; divisor_i = 32'd4;
    @(posedge clk);
    #1 start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom;
    @(negedge clk);
    check("b2b_busy", {63'd0, busy_o}, 64'd1);
    check("b2b_result_held", result_o, {32'h2, 32'hE});
    wait_done(bc, got);
    check("b2b_second_ready", {63'd0, got}, 64'd1);
    check("b2b_second_result", result_o, {32'h3, 32'h3});
    check("b2b_busy_cycles", 64'(bc + 1), 64'd32);

    // start during BUSY is ignored
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (5) @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd15; divisor_i = 32'd4;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(bc, got);
    check("busy_start_ready", {63'd0, got}, 64'd1);
    check("busy_start_result", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    check("busy_start_cycles", 64'(bc + 5), 64'd32);

    check("busy_ready_exclusive", 64'(overlap_seen), '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
